// File: rtl/comp_pkg.sv
// ============================================================================
// comp_pkg : shared FSM state type and default operand width for the
//            sequential multiply/divide units.
// Rev 1.0
// ============================================================================
`default_nettype none

package comp_pkg;

  localparam int COMP_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } comp_state_e;

endpackage : comp_pkg

`default_nettype wire

// File: rtl/comp_mul_step.sv
// ============================================================================
// comp_mul_step : one add-and-shift iteration of the shift-add multiplier.
// Rev 1.0
// ============================================================================
`default_nettype none

module comp_mul_step
  import comp_pkg::*;
#(
  parameter int WIDTH = COMP_WIDTH
) (
  input  logic [2*WIDTH-1:0] prod,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] prod_next
);

  logic [WIDTH:0] w_addend;
  logic [WIDTH:0] w_sum;

  always_comb begin
    w_addend  = prod[0] ? {1'b0, mcand} : '0;
    // The carry out of the upper half lands in the MSB after the shift.
    w_sum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + w_addend;
    prod_next = {w_sum, prod[WIDTH-1:1]};
  end

endmodule : comp_mul_step

`default_nettype wire

// File: rtl/comp_multiplier.sv
// ============================================================================
// comp_multiplier : sequential unsigned shift-add multiplier, Run/Ready
//                   handshake, one partial-product step per clock.
// Rev 1.0
// ============================================================================
`default_nettype none

module comp_multiplier
  import comp_pkg::*;
#(
  parameter int WIDTH = COMP_WIDTH
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               Run,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic [2*WIDTH-1:0] Product,
  output logic               Ready
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  comp_state_e        state_q, state_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] w_step_prod;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;

  comp_mul_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .prod      (prod_q),
    .mcand     (mcand_q),
    .prod_next (w_step_prod)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (Run) begin
          mcand_d = Multiplicand;
          prod_d  = {{WIDTH{1'b0}}, Multiplier};
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        prod_d = w_step_prod;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Run must be seen low before another load can happen.
        if (!Run) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == DONE);
  end

  assign Product = prod_q;
  assign Ready   = ready_q;

endmodule : comp_multiplier

`default_nettype wire

// File: tb/tb_comp_multiplier.sv
// ============================================================================
// tb_comp_multiplier : directed vectors with a queue scoreboard for
//                      comp_multiplier.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_comp_multiplier;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  typedef struct {
    logic [2*WIDTH-1:0] prod;
    int                 cyc;
  } exp_t;

  logic               clk;
  logic               Reset;
  logic               Run;
  logic [WIDTH-1:0]   Multiplicand;
  logic [WIDTH-1:0]   Multiplier;
  logic [2*WIDTH-1:0] Product;
  logic               Ready;

  int   cyc;
  int   checks;
  int   errors;
  bit   stim_done;
  exp_t sb_q[$];

  comp_multiplier #(
    .WIDTH (WIDTH)
  ) dut (
    .clk          (clk),
    .Reset        (Reset),
    .Run          (Run),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Product      (Product),
    .Ready        (Ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [2*WIDTH-1:0] act,
                       input logic [2*WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising Ready pops one expected result.
  initial begin : monitor
    logic rdy_prev;
    exp_t e;
    rdy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (Ready === 1'b1 && rdy_prev !== 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got Ready=1 with no pending op, expected 0 (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          check("sb_product", Product, e.prod);
          check("sb_latency", 64'(cyc), 64'(e.cyc));
        end
      end
      rdy_prev = Ready;
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < LAT + 8; i++) begin
      @(negedge clk);
      if (Ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got Ready=0 expected 1 (cycle %0d)", cyc);
    end
  endtask

  // Start one operation; optionally scramble inputs and drop Run after the
  // load, and optionally hold Run high for a few cycles in DONE.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2*WIDTH-1:0] exp, input bit scramble,
                        input int hold);
    exp_t e;
    bit   ok;
    @(negedge clk);
    Multiplicand = a;
    Multiplier   = b;
    Run          = 1'b1;
    e.prod       = exp;
    e.cyc        = cyc + LAT;
    sb_q.push_back(e);
    @(negedge clk);
    if (scramble) begin
      Multiplicand = '0;
      Multiplier   = '0;
      Run          = 1'b0;
    end
    wait_ready(ok);
    if (ok) begin
      Run = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_ready", 64'(Ready), 64'd1);
        check("hold_product", Product, exp);
      end
      Run = 1'b0;
      @(negedge clk);
      check("ready_fall", 64'(Ready), 64'd0);
      check("product_retained", Product, exp);
    end
    Run = 1'b0;
  endtask

  initial begin : stimulus
    checks       = 0;
    errors       = 0;
    stim_done    = 1'b0;
    Reset        = 1'b1;
    Run          = 1'b0;
    Multiplicand = '0;
    Multiplier   = '0;
    repeat (2) @(negedge clk);
    check("reset_product", Product, '0);
    check("reset_ready", 64'(Ready), 64'd0);
    Reset = 1'b0;

    run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 0);
    run_op(32'h0000_0000, 32'h1234_5678, 64'h0, 1'b0, 0);
    run_op(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b0, 0);
    run_op(32'hDEAD_BEEF, 32'd2, 64'h0000_0001_BD5B_7DDE, 1'b1, 0);
    run_op(32'h0000_0001, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b0, 0);
    run_op(32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 1'b0, 0);

    // Abort mid-computation with Reset; no result is expected from it.
    @(negedge clk);
    Multiplicand = 32'h0000_00AB;
    Multiplier   = 32'h0000_00CD;
    Run          = 1'b1;
    repeat (10) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    check("abort_product", Product, '0);
    check("abort_ready", 64'(Ready), 64'd0);
    Reset = 1'b0;
    Run   = 1'b0;

    run_op(32'd7, 32'd6, 64'd42, 1'b0, 0);
    run_op(32'd9, 32'd11, 64'd99, 1'b0, 5);

    // Reset coinciding with Run must not load.
    @(negedge clk);
    Multiplicand = 32'd4;
    Multiplier   = 32'd4;
    Run          = 1'b1;
    Reset        = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    Run   = 1'b0;
    check("rst_run_product", Product, '0);
    repeat (LAT + 4) @(negedge clk);
    check("rst_run_no_ready", 64'(Ready), 64'd0);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    stim_done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    if (!stim_done) begin
      $display("FAIL watchdog: simulation did not complete, got cycle %0d", cyc);
      $fatal(1, "watchdog");
    end
  end

endmodule : tb_comp_multiplier

`default_nettype wire
